// File: rtl/cpu_defs.sv
// Shared MIPS pipeline definitions: ExcCodes, access sizes, MEM-stage FSM states.
// Latency: none (constants and a pure helper function).
// Backpressure: n/a.
package cpu_defs;

  // MIPS Cause.ExcCode values raised by the MEM stage
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;

  // MemAccessSize encodings; 2'b11 behaves as a word
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Bus access FSM states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Natural alignment check for a data access of the given size
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      default:   mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Byte-lane steering: store byte enables and replication, load extraction and extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module load_align
  import cpu_defs::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_data_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] store_lanes_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  // Lane selection and extension for the three access sizes
  always_comb begin
    shifted = read_data_i >> {offset_i, 3'b000};
    case (size_i)
      SIZE_BYTE: begin
        byte_en_o     = 4'b0001 << offset_i;
        store_lanes_o = {4{store_data_i[7:0]}};
        load_data_o   = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        byte_en_o     = offset_i[1] ? 4'b1100 : 4'b0011;
        store_lanes_o = {2{store_data_i[15:0]}};
        load_data_o   = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byte_en_o     = 4'b1111;
        store_lanes_o = store_data_i;
        load_data_o   = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MIPS MEM stage + MEM/WB register: data bus loads/stores, exception arbitration, writeback.
// Latency: non-memory ops 1 edge; bus access 3 edges minimum (IDLE->BUSY->DONE->WB).
// Backpressure: ready held low from access issue until the bus acks or times out.
module mem_access
  import cpu_defs::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        MemRAMReadEnable,
  input  logic        MemRAMWriteEnable,
  input  logic [1:0]  MemAccessSize,
  input  logic        MemSignExtend,
  input  logic [31:0] MemAddress,
  input  logic [31:0] MemStoreData,
  input  logic [4:0]  MemWriteAddress,
  input  logic        MemWriteRegister,
  input  logic [31:0] MemWriteData,
  input  logic        MemValidInstruction,
  input  logic        Memprivilege,
  input  logic        Memsyscall,
  input  logic        TLBMissRead,
  input  logic        TLBMissWrite,
  input  logic [31:0] MemPC,
  input  logic [31:0] MemBadAddress,
  input  logic        MemIsInDelaySlot,
  output logic        RAMRequest,
  output logic        RAMWrite,
  output logic [31:0] RAMAddress,
  output logic [31:0] RAMWriteData,
  output logic [3:0]  RAMByteEnable,
  input  logic        RAMAck,
  input  logic [31:0] RAMReadData,
  output logic        ready,
  output logic [4:0]  WbWriteAddress,
  output logic        WbWriteRegister,
  output logic [31:0] WbWriteData,
  output logic        ExceptionValid,
  output logic [4:0]  ExceptionCode,
  output logic [31:0] ExceptionPC,
  output logic [31:0] ExceptionBadAddress,
  output logic        ExceptionDelaySlot
);

  // Last BUSY count value before the access is abandoned as a bus error
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        dbe_q, dbe_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_q, req_d;
  logic        rw_q, rw_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] rwdata_q, rwdata_d;
  logic [3:0]  rbe_q, rbe_d;

  logic [4:0]  wb_addr_q, wb_addr_d;
  logic        wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_vld_q, exc_vld_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic [31:0] exc_bad_q, exc_bad_d;
  logic        exc_bd_q, exc_bd_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  logic        is_mem;
  logic        mis;
  logic        exc_pre;
  logic        exc_hit;
  logic [4:0]  exc_code;
  logic [31:0] exc_bad;
  logic        access;
  logic [31:0] epc;

  load_align u_align (
    .size_i        (MemAccessSize),
    .offset_i      (MemAddress[1:0]),
    .sign_i        (MemSignExtend),
    .store_data_i  (MemStoreData),
    .read_data_i   (rdata_q),
    .byte_en_o     (lane_be),
    .store_lanes_o (lane_wdata),
    .load_data_o   (load_data)
  );

  assign is_mem = MemRAMReadEnable | MemRAMWriteEnable;
  assign mis    = is_mem & misaligned(MemAccessSize, MemAddress[1:0]);
  assign epc    = MemIsInDelaySlot ? (MemPC - 32'd4) : MemPC;

  // Exception priority; the bus error is only visible in DONE and ranks lowest
  always_comb begin
    exc_pre  = 1'b1;
    exc_code = 5'd0;
    exc_bad  = 32'd0;
    if (TLBMissRead) begin
      exc_code = EXC_TLBL;
      exc_bad  = MemBadAddress;
    end else if (!MemValidInstruction) begin
      exc_code = EXC_RI;
    end else if (Memprivilege) begin
      exc_code = EXC_CPU;
    end else if (Memsyscall) begin
      exc_code = EXC_SYS;
    end else if (mis) begin
      exc_code = MemRAMReadEnable ? EXC_ADEL : EXC_ADES;
      exc_bad  = MemAddress;
    end else if (TLBMissWrite) begin
      exc_code = EXC_TLBS;
      exc_bad  = MemBadAddress;
    end else begin
      exc_pre = 1'b0;
      if (state_q == DONE && dbe_q) begin
        exc_code = EXC_DBE;
        exc_bad  = MemAddress;
      end
    end
  end

  assign exc_hit = exc_pre | ((state_q == DONE) & dbe_q);
  assign access  = is_mem & ~exc_pre;

  // Bus FSM: issue, wait for ack or timeout, then release the stage for one cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    dbe_d    = dbe_q;
    rdata_d  = rdata_q;
    req_d    = req_q;
    rw_d     = rw_q;
    raddr_d  = raddr_q;
    rwdata_d = rwdata_q;
    rbe_d    = rbe_q;
    ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !flush) begin
          state_d  = BUSY;
          cnt_d    = 8'd0;
          kill_d   = 1'b0;
          dbe_d    = 1'b0;
          req_d    = 1'b1;
          rw_d     = MemRAMWriteEnable;
          raddr_d  = {MemAddress[31:2], 2'b00};
          rwdata_d = lane_wdata;
          rbe_d    = lane_be;
        end else begin
          ready = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (flush) kill_d = 1'b1;
        if (RAMAck) begin
          rdata_d = RAMReadData;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          req_d   = 1'b0;
          dbe_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready   = 1'b1;
        kill_d  = 1'b0;
        dbe_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // MEM/WB and exception register loads; strobes fall back to zero when not loading
  always_comb begin
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_reg_d   = 1'b0;
    exc_vld_d  = 1'b0;
    exc_code_d = 5'd0;
    exc_pc_d   = 32'd0;
    exc_bad_d  = 32'd0;
    exc_bd_d   = 1'b0;
    if (ready) begin
      if (flush || (state_q == DONE && kill_q)) begin
        wb_addr_d = 5'd0;
        wb_data_d = 32'd0;
      end else if (exc_hit) begin
        wb_addr_d  = MemWriteAddress;
        wb_data_d  = MemWriteData;
        exc_vld_d  = 1'b1;
        exc_code_d = exc_code;
        exc_pc_d   = epc;
        exc_bad_d  = exc_bad;
        exc_bd_d   = MemIsInDelaySlot;
      end else begin
        wb_addr_d = MemWriteAddress;
        wb_reg_d  = MemWriteRegister & ~MemRAMWriteEnable;
        wb_data_d = (state_q == DONE && MemRAMReadEnable) ? load_data : MemWriteData;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      kill_q     <= 1'b0;
      dbe_q      <= 1'b0;
      rdata_q    <= 32'd0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      raddr_q    <= 32'd0;
      rwdata_q   <= 32'd0;
      rbe_q      <= 4'd0;
      wb_addr_q  <= 5'd0;
      wb_reg_q   <= 1'b0;
      wb_data_q  <= 32'd0;
      exc_vld_q  <= 1'b0;
      exc_code_q <= 5'd0;
      exc_pc_q   <= 32'd0;
      exc_bad_q  <= 32'd0;
      exc_bd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      dbe_q      <= dbe_d;
      rdata_q    <= rdata_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      raddr_q    <= raddr_d;
      rwdata_q   <= rwdata_d;
      rbe_q      <= rbe_d;
      wb_addr_q  <= wb_addr_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      exc_vld_q  <= exc_vld_d;
      exc_code_q <= exc_code_d;
      exc_pc_q   <= exc_pc_d;
      exc_bad_q  <= exc_bad_d;
      exc_bd_q   <= exc_bd_d;
    end
  end

  assign RAMRequest          = req_q;
  assign RAMWrite            = rw_q;
  assign RAMAddress          = raddr_q;
  assign RAMWriteData        = rwdata_q;
  assign RAMByteEnable       = rbe_q;
  assign WbWriteAddress      = wb_addr_q;
  assign WbWriteRegister     = wb_reg_q;
  assign WbWriteData         = wb_data_q;
  assign ExceptionValid      = exc_vld_q;
  assign ExceptionCode       = exc_code_q;
  assign ExceptionPC         = exc_pc_q;
  assign ExceptionBadAddress = exc_bad_q;
  assign ExceptionDelaySlot  = exc_bd_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scoreboard of expected writebacks/exceptions popped on each DUT strobe.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A simple bus model acks after a chosen number of BUSY cycles or never.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        MemRAMReadEnable, MemRAMWriteEnable;
  logic [1:0]  MemAccessSize;
  logic        MemSignExtend;
  logic [31:0] MemAddress, MemStoreData;
  logic [4:0]  MemWriteAddress;
  logic        MemWriteRegister;
  logic [31:0] MemWriteData;
  logic        MemValidInstruction, Memprivilege, Memsyscall;
  logic        TLBMissRead, TLBMissWrite;
  logic [31:0] MemPC, MemBadAddress;
  logic        MemIsInDelaySlot;
  logic        RAMRequest, RAMWrite;
  logic [31:0] RAMAddress, RAMWriteData;
  logic [3:0]  RAMByteEnable;
  logic        RAMAck;
  logic [31:0] RAMReadData;
  logic        ready;
  logic [4:0]  WbWriteAddress;
  logic        WbWriteRegister;
  logic [31:0] WbWriteData;
  logic        ExceptionValid;
  logic [4:0]  ExceptionCode;
  logic [31:0] ExceptionPC, ExceptionBadAddress;
  logic        ExceptionDelaySlot;

  typedef struct {
    logic        exc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] bad;
    logic        bd;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  int          stall, busy;
  logic [3:0]  be;
  logic [31:0] wd, ra;
  logic        rw;
  logic [31:0] d;

  mem_access #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .MemRAMReadEnable(MemRAMReadEnable), .MemRAMWriteEnable(MemRAMWriteEnable),
    .MemAccessSize(MemAccessSize), .MemSignExtend(MemSignExtend),
    .MemAddress(MemAddress), .MemStoreData(MemStoreData),
    .MemWriteAddress(MemWriteAddress), .MemWriteRegister(MemWriteRegister),
    .MemWriteData(MemWriteData), .MemValidInstruction(MemValidInstruction),
    .Memprivilege(Memprivilege), .Memsyscall(Memsyscall),
    .TLBMissRead(TLBMissRead), .TLBMissWrite(TLBMissWrite),
    .MemPC(MemPC), .MemBadAddress(MemBadAddress), .MemIsInDelaySlot(MemIsInDelaySlot),
    .RAMRequest(RAMRequest), .RAMWrite(RAMWrite), .RAMAddress(RAMAddress),
    .RAMWriteData(RAMWriteData), .RAMByteEnable(RAMByteEnable),
    .RAMAck(RAMAck), .RAMReadData(RAMReadData), .ready(ready),
    .WbWriteAddress(WbWriteAddress), .WbWriteRegister(WbWriteRegister),
    .WbWriteData(WbWriteData), .ExceptionValid(ExceptionValid),
    .ExceptionCode(ExceptionCode), .ExceptionPC(ExceptionPC),
    .ExceptionBadAddress(ExceptionBadAddress), .ExceptionDelaySlot(ExceptionDelaySlot)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    MemRAMReadEnable = 0; MemRAMWriteEnable = 0; MemAccessSize = 2'b10; MemSignExtend = 0;
    MemAddress = 0; MemStoreData = 0; MemWriteAddress = 0; MemWriteRegister = 0;
    MemWriteData = 0; MemValidInstruction = 1; Memprivilege = 0; Memsyscall = 0;
    TLBMissRead = 0; TLBMissWrite = 0; MemPC = 0; MemBadAddress = 0; MemIsInDelaySlot = 0;
  endtask

  task automatic set_mem(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] waddr, input logic wreg);
    bubble();
    MemRAMReadEnable = ld; MemRAMWriteEnable = st; MemAccessSize = sz; MemSignExtend = sx;
    MemAddress = addr; MemStoreData = sdata; MemWriteAddress = waddr; MemWriteRegister = wreg;
    MemWriteData = 32'h5555_5555; MemPC = 32'h0000_1000;
  endtask

  task automatic push_wb(input logic [4:0] a, input logic [31:0] v);
    exp_t e;
    e.exc = 0; e.waddr = a; e.wdata = v; e.code = 0; e.pc = 0; e.bad = 0; e.bd = 0;
    sb.push_back(e);
  endtask

  task automatic push_exc(input logic [4:0] c, input logic [31:0] pc, input logic [31:0] bad,
                          input logic bd);
    exp_t e;
    e.exc = 1; e.waddr = 0; e.wdata = 0; e.code = c; e.pc = pc; e.bad = bad; e.bd = bd;
    sb.push_back(e);
  endtask

  // Present the current instruction until the stage accepts it; the bus acks in
  // BUSY cycle ack_at (-1 never) and flush is pulsed in BUSY cycle flush_at.
  task automatic run(input int ack_at, input int flush_at, input logic [31:0] rdat,
                     output int st, output int bc, output logic [3:0] obe,
                     output logic [31:0] owd, output logic [31:0] ora, output logic orw);
    bit done = 0;
    st = 0; bc = 0; obe = 0; owd = 0; ora = 0; orw = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (ready) done = 1;
      else begin
        st++;
        @(posedge clock); #1;
        RAMAck = 0; flush = 0;
        if (RAMRequest) begin
          if (bc == 0) begin obe = RAMByteEnable; owd = RAMWriteData; ora = RAMAddress; orw = RAMWrite; end
          if (bc == ack_at) begin RAMAck = 1; RAMReadData = rdat; end
          if (bc == flush_at) flush = 1;
          bc++;
        end
      end
    end
    if (!done) chk("cycle_bound", 0, 1);
    @(posedge clock); #1;
    RAMAck = 0; flush = 0;
    bubble();
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input int off, input bit sx,
                                             input logic [31:0] v);
    logic [7:0]  b;
    logic [15:0] h;
    b = v[8*off +: 8];
    h = (off >= 2) ? v[31:16] : v[15:0];
    if (sz == 2'b00) return sx ? 32'(signed'(b)) : {24'd0, b};
    if (sz == 2'b01) return sx ? 32'(signed'(h)) : {16'd0, h};
    return v;
  endfunction

  // Every writeback or exception strobe must match the oldest expectation
  always @(negedge clock) begin
    if (reset === 1'b1 && (WbWriteRegister || ExceptionValid)) begin
      if (sb.size() == 0) chk("unexpected_strobe", 32'({WbWriteRegister, ExceptionValid}), 0);
      else begin
        got_e = sb.pop_front();
        chk("exc_valid", 32'(ExceptionValid), 32'(got_e.exc));
        if (got_e.exc) begin
          chk("exc_code", 32'(ExceptionCode), 32'(got_e.code));
          chk("exc_pc", ExceptionPC, got_e.pc);
          chk("exc_bad", ExceptionBadAddress, got_e.bad);
          chk("exc_bd", 32'(ExceptionDelaySlot), 32'(got_e.bd));
          chk("exc_wbreg", 32'(WbWriteRegister), 0);
        end else begin
          chk("wb_addr", 32'(WbWriteAddress), 32'(got_e.waddr));
          chk("wb_data", WbWriteData, got_e.wdata);
        end
      end
    end
  end

  initial begin
    bubble(); flush = 0; RAMAck = 0; RAMReadData = 0; reset = 1;
    #2 reset = 0;
    #10;
    chk("rst_ram_ctl", 32'({RAMRequest, RAMWrite, RAMByteEnable}), 0);
    chk("rst_ram_addr", RAMAddress, 0);
    chk("rst_ram_wdata", RAMWriteData, 0);
    chk("rst_wb", 32'({WbWriteAddress, WbWriteRegister}), 0);
    chk("rst_wb_data", WbWriteData, 0);
    chk("rst_exc", 32'({ExceptionValid, ExceptionCode, ExceptionDelaySlot}), 0);
    chk("rst_exc_addr", ExceptionPC | ExceptionBadAddress, 0);
    chk("rst_ready", 32'(ready), 1);
    @(posedge clock); #1 reset = 1;

    // Word load, ack in the first BUSY cycle
    set_mem(1, 0, 2'b10, 0, 32'h8000_1004, 0, 5'd5, 1);
    push_wb(5'd5, 32'hDEAD_BEEF);
    run(0, -1, 32'hDEAD_BEEF, stall, busy, be, wd, ra, rw);
    chk("wl_stall", stall, 2);
    chk("wl_addr", ra, 32'h8000_1004);
    chk("wl_be", 32'(be), 32'hF);
    chk("wl_rw", 32'(rw), 0);

    // Byte load from lane 3, signed then unsigned
    set_mem(1, 0, 2'b00, 1, 32'h0000_0103, 0, 5'd6, 1);
    push_wb(5'd6, 32'hFFFF_FF80);
    run(0, -1, 32'h80FF_FFFF, stall, busy, be, wd, ra, rw);
    chk("lbs_be", 32'(be), 32'h8);
    set_mem(1, 0, 2'b00, 0, 32'h0000_0103, 0, 5'd6, 1);
    push_wb(5'd6, 32'h0000_0080);
    run(0, -1, 32'h80FF_FFFF, stall, busy, be, wd, ra, rw);

    // Halfword store to upper half; no register write may appear
    set_mem(0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 5'd9, 1);
    run(0, -1, 32'h0, stall, busy, be, wd, ra, rw);
    chk("sh_be", 32'(be), 32'hC);
    chk("sh_wdata", wd, 32'hABCD_ABCD);
    chk("sh_rw", 32'(rw), 1);
    chk("sh_addr", ra, 32'h0000_0200);

    // Misaligned word load: no bus request, AdEL
    set_mem(1, 0, 2'b10, 0, 32'h0000_0006, 0, 5'd3, 1);
    MemPC = 32'h200;
    push_exc(5'd4, 32'h200, 32'h6, 0);
    run(-1, -1, 0, stall, busy, be, wd, ra, rw);
    chk("adel_stall", stall, 0);
    chk("adel_busy", busy, 0);
    set_mem(1, 0, 2'b10, 0, 32'h0000_0006, 0, 5'd3, 1);
    MemPC = 32'h100; MemIsInDelaySlot = 1;
    push_exc(5'd4, 32'hFC, 32'h6, 1);
    run(-1, -1, 0, stall, busy, be, wd, ra, rw);

    // TLB read miss outranks a misaligned store; syscall carries no BadVAddr
    set_mem(0, 1, 2'b10, 0, 32'h0000_0006, 0, 5'd3, 0);
    TLBMissRead = 1; MemBadAddress = 32'hBADA_0000; MemPC = 32'h300;
    push_exc(5'd2, 32'h300, 32'hBADA_0000, 0);
    run(-1, -1, 0, stall, busy, be, wd, ra, rw);
    set_mem(0, 0, 2'b10, 0, 32'h0000_0040, 0, 5'd3, 1);
    Memsyscall = 1; MemPC = 32'h500;
    push_exc(5'd8, 32'h500, 32'h0, 0);
    run(-1, -1, 0, stall, busy, be, wd, ra, rw);

    // No ack: 16 request cycles, then data bus error
    set_mem(1, 0, 2'b10, 0, 32'h0000_0300, 0, 5'd4, 1);
    MemPC = 32'h400;
    push_exc(5'd7, 32'h400, 32'h300, 0);
    run(-1, -1, 0, stall, busy, be, wd, ra, rw);
    chk("tmo_req_cycles", busy, 16);
    chk("tmo_stall", stall, 17);

    // Reset in the middle of a bus access
    set_mem(1, 0, 2'b10, 0, 32'h0000_0500, 0, 5'd8, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("rmid_busy_req", 32'(RAMRequest), 1);
    reset = 0;
    bubble();
    #1;
    chk("rmid_ram", 32'({RAMRequest, RAMWrite, RAMByteEnable}), 0);
    chk("rmid_ram_addr", RAMAddress | RAMWriteData, 0);
    chk("rmid_wb", 32'({WbWriteAddress, WbWriteRegister}) | WbWriteData, 0);
    chk("rmid_exc", 32'({ExceptionValid, ExceptionCode, ExceptionDelaySlot}), 0);
    chk("rmid_ready", 32'(ready), 1);
    @(posedge clock); #1 reset = 1;
    @(negedge clock);
    chk("rmid_idle_req", 32'(RAMRequest), 0);
    @(posedge clock); #1;

    // Flush during BUSY, ack three cycles later: killed, then normal traffic
    set_mem(1, 0, 2'b10, 0, 32'h0000_0600, 0, 5'd10, 1);
    run(3, 0, 32'h7777_7777, stall, busy, be, wd, ra, rw);
    chk("flush_stall", stall, 5);
    set_mem(1, 0, 2'b10, 0, 32'h0000_0604, 0, 5'd11, 1);
    push_wb(5'd11, 32'h1122_3344);
    run(0, -1, 32'h1122_3344, stall, busy, be, wd, ra, rw);
    chk("postflush_stall", stall, 2);
    set_mem(0, 0, 2'b10, 0, 32'h0, 0, 5'd7, 1);
    MemWriteData = 32'hCAFE_F00D;
    push_wb(5'd7, 32'hCAFE_F00D);
    run(-1, -1, 0, stall, busy, be, wd, ra, rw);
    chk("alu_stall", stall, 0);

    // Sub-word loads over every legal offset with random data
    for (int off = 0; off < 4; off++) begin
      for (int sx = 0; sx < 2; sx++) begin
        d = $urandom;
        set_mem(1, 0, 2'b00, sx != 0, 32'h1000 | 32'(off), 0, 5'd12, 1);
        push_wb(5'd12, model_load(2'b00, off, sx != 0, d));
        run(0, -1, d, stall, busy, be, wd, ra, rw);
        chk("lb_be", 32'(be), 32'(4'b0001 << off));
      end
    end
    for (int off = 0; off < 4; off += 2) begin
      for (int sx = 0; sx < 2; sx++) begin
        d = $urandom | 32'h8000_8000;
        set_mem(1, 0, 2'b01, sx != 0, 32'h2000 | 32'(off), 0, 5'd13, 1);
        push_wb(5'd13, model_load(2'b01, off, sx != 0, d));
        run(0, -1, d, stall, busy, be, wd, ra, rw);
        chk("lh_be", 32'(be), (off == 2) ? 32'hC : 32'h3);
      end
    end

    repeat (4) @(posedge clock);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
